// File: rtl/dmi_jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller in front of the DMI JTAG front-end.
// Decodes TMS into the 16-state TAP FSM. Holds the IR and the local IDCODE, BYPASS and
// DTMCS data registers, and forwards the DMI scan path downstream.
module dmi_jtag_tap_ctrl #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       td_o,
  output logic       tdo_oe_o,
  input  logic       testmode_i,
  output logic       test_logic_reset_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_dr_o,
  output logic       dmi_access_o,
  output logic       dtmcs_select_o,
  output logic       dmi_reset_o,
  input  logic [1:0] dmi_error_i,
  output logic       dmi_tdi_o,
  input  logic       dmi_tdo_i
);

  localparam logic [3:0] TestLogicReset = 4'd0;
  localparam logic [3:0] RunTestIdle    = 4'd1;
  localparam logic [3:0] SelectDrScan   = 4'd2;
  localparam logic [3:0] CaptureDr      = 4'd3;
  localparam logic [3:0] ShiftDr        = 4'd4;
  localparam logic [3:0] Exit1Dr        = 4'd5;
  localparam logic [3:0] PauseDr        = 4'd6;
  localparam logic [3:0] Exit2Dr        = 4'd7;
  localparam logic [3:0] UpdateDr       = 4'd8;
  localparam logic [3:0] SelectIrScan   = 4'd9;
  localparam logic [3:0] CaptureIr      = 4'd10;
  localparam logic [3:0] ShiftIr        = 4'd11;
  localparam logic [3:0] Exit1Ir        = 4'd12;
  localparam logic [3:0] PauseIr        = 4'd13;
  localparam logic [3:0] Exit2Ir        = 4'd14;
  localparam logic [3:0] UpdateIr       = 4'd15;

  localparam logic [IrLength-1:0] IrIdcode    = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs     = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmiAccess = IrLength'(5'h11);
  // Capture pattern: LSBs 01 as 1149.1 requires.
  localparam logic [IrLength-1:0] IrCapture   = IrLength'(5'b00101);

  logic [3:0]          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [31:0]         idcode_q, idcode_d, dtmcs_q, dtmcs_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic                idcode_sel, tdo_mux, tck_tdo;

  // TAP state transitions selected by TMS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  assign test_logic_reset_o = (state_q == TestLogicReset);
  assign capture_dr_o       = (state_q == CaptureDr);
  assign shift_dr_o         = (state_q == ShiftDr);
  assign update_dr_o        = (state_q == UpdateDr);
  assign dmi_access_o       = (ir_q == IrDmiAccess);
  assign dtmcs_select_o     = (ir_q == IrDtmcs);
  assign idcode_sel         = (ir_q == IrIdcode);
  assign dmi_tdi_o          = td_i;
  assign dmi_reset_o        = update_dr_o & dtmcs_select_o & dtmcs_q[16];

  // Instruction register: capture, LSB-first shift, update; TLR restores IDCODE.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    unique case (state_q)
      TestLogicReset: ir_d       = IrIdcode;
      CaptureIr:      ir_shift_d = IrCapture;
      ShiftIr:        ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
      UpdateIr:       ir_d       = ir_shift_q;
      default:        ;
    endcase
  end

  // Local data registers; only the one selected by IR captures or shifts.
  // Unknown IR codes fall through to BYPASS.
  always_comb begin
    idcode_d = idcode_q;
    dtmcs_d  = dtmcs_q;
    bypass_d = bypass_q;
    if (capture_dr_o) begin
      if (idcode_sel) begin
        idcode_d = IdcodeValue;
      end else if (dtmcs_select_o) begin
        dtmcs_d = {17'd0, 3'd1, dmi_error_i, 6'd7, 4'd1};
      end else if (!dmi_access_o) begin
        bypass_d = 1'b0;
      end
    end else if (shift_dr_o) begin
      if (idcode_sel) begin
        idcode_d = {td_i, idcode_q[31:1]};
      end else if (dtmcs_select_o) begin
        dtmcs_d = {td_i, dtmcs_q[31:1]};
      end else if (!dmi_access_o) begin
        bypass_d = td_i;
      end
    end
  end

  // Serial output selection ahead of the falling-edge flop.
  always_comb begin
    tdo_mux = 1'b0;
    if (state_q == ShiftIr) begin
      tdo_mux = ir_shift_q[0];
    end else if (shift_dr_o) begin
      if (idcode_sel)          tdo_mux = idcode_q[0];
      else if (dtmcs_select_o) tdo_mux = dtmcs_q[0];
      else if (dmi_access_o)   tdo_mux = dmi_tdo_i;
      else                     tdo_mux = bypass_q;
    end
    tdo_oe_d = (state_q == ShiftIr) | shift_dr_o;
    tdo_d    = tdo_oe_d ? tdo_mux : 1'b0;
  end

  // Rising-edge TAP state.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q    <= TestLogicReset;
      ir_q       <= IrIdcode;
      ir_shift_q <= '0;
      idcode_q   <= '0;
      dtmcs_q    <= '0;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      dtmcs_q    <= dtmcs_d;
      bypass_q   <= bypass_d;
    end
  end

  // In DFT mode the TDO flop runs on the true clock so scan sees a single clock edge.
  assign tck_tdo = testmode_i ? tck_i : ~tck_i;

  // TDO launched on the falling edge of TCK.
  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign td_o     = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule

// File: tb/tb_dmi_jtag_tap_ctrl.sv
// Self-checking bench for dmi_jtag_tap_ctrl. Scans are modelled as whole transactions:
// a DR of length L emits its captured value, then the bits shifted in, LSB-first.
module tb_dmi_jtag_tap_ctrl;

  localparam logic [31:0] Idcode = 32'h0000_0001;

  logic tck_i = 1'b0, trst_ni = 1'b0, tms_i = 1'b1, td_i = 1'b0;
  logic td_o, tdo_oe_o, testmode_i = 1'b0;
  logic test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o;
  logic dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o, dmi_tdo_i = 1'b0;
  logic [1:0] dmi_error_i = 2'd0;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int n_cap, n_shift, n_upd, n_rst, n_rst_upd, n_dmi, n_tick, n_oe;
  logic [63:0] dout, dexp;

  dmi_jtag_tap_ctrl #(.IrLength(5), .IdcodeValue(Idcode)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
    .tdo_oe_o(tdo_oe_o), .testmode_i(testmode_i), .test_logic_reset_o(test_logic_reset_o),
    .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o), .capture_dr_o(capture_dr_o),
    .dmi_access_o(dmi_access_o), .dtmcs_select_o(dtmcs_select_o), .dmi_reset_o(dmi_reset_o),
    .dmi_error_i(dmi_error_i), .dmi_tdi_o(dmi_tdi_o), .dmi_tdo_i(dmi_tdo_i)
  );

  initial forever #5 tck_i = ~tck_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_cap = 0; n_shift = 0; n_upd = 0; n_rst = 0; n_rst_upd = 0;
    n_dmi = 0; n_tick = 0; n_oe = 0; dout = '0; dexp = '0;
  endtask

  // One TCK cycle, entered and left just after a falling edge.
  task automatic tick(input logic tms, input logic tdi);
    tms_i = tms; td_i = tdi; dmi_tdo_i = 1'($urandom);
    @(posedge tck_i); #1;
    n_cap     += int'(capture_dr_o);
    n_shift   += int'(shift_dr_o);
    n_upd     += int'(update_dr_o);
    n_rst     += int'(dmi_reset_o);
    n_rst_upd += int'(dmi_reset_o & update_dr_o);
    n_dmi     += int'(dmi_access_o);
    n_tick++;
    @(negedge tck_i); #1;
    if (tdo_oe_o) begin
      if (n_oe < 64) begin
        dout[n_oe] = td_o;
        dexp[n_oe] = dmi_tdo_i;
      end
      n_oe++;
    end
  endtask

  // RunTestIdle -> full IR scan -> RunTestIdle.
  task automatic scan_ir(input logic [4:0] din);
    clear_counts();
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int k = 0; k < 5; k++) tick(k == 4, din[k]);
    tick(1, 0); tick(0, 0);
  endtask

  // RunTestIdle -> n-bit DR scan -> RunTestIdle.
  task automatic scan_dr(input int n, input logic [63:0] din);
    clear_counts();
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int k = 0; k < n; k++) tick(k == n - 1, din[k]);
    tick(1, 0); tick(0, 0);
  endtask

  // Captured contents followed by shifted-in bits, as seen on the serial output.
  function automatic logic [95:0] dr_stream(input logic [4:0] ir, input logic [63:0] din,
                                            input logic [1:0] err);
    logic [31:0] cap;
    if (ir == 5'h01) return {din, Idcode};
    if (ir == 5'h10) begin
      cap = 32'h0000_1071 | (32'(err) << 10);
      return {din, cap};
    end
    return {31'd0, din, 1'b0};
  endfunction

  function automatic logic [63:0] mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  logic [63:0] data;
  logic [95:0] full;
  logic [4:0]  code;
  int          len;
  logic [4:0]  codes [5];

  initial begin
    codes[0] = 5'h01; codes[1] = 5'h10; codes[2] = 5'h11; codes[3] = 5'h1f; codes[4] = 5'h00;
    clear_counts();
    @(negedge tck_i); #1;
    check("reset_tlr", 64'(test_logic_reset_o), 64'd1);
    check("reset_td_o", 64'(td_o), 64'd0);
    check("reset_oe", 64'(tdo_oe_o), 64'd0);
    check("reset_dmi_access", 64'(dmi_access_o), 64'd0);
    trst_ni = 1'b1;
    tick(0, 0);
    check("rti_tlr_low", 64'(test_logic_reset_o), 64'd0);

    // IDCODE read straight after reset.
    scan_dr(32, 64'(32'hffff_ffff));
    check("idcode_data", dout, 64'(Idcode));
    check("idcode_oe_cnt", 64'(n_oe), 64'd32);
    check("idcode_strobes", {32'(n_cap), 16'(n_shift), 16'(n_upd)}, {32'd1, 16'd32, 16'd1});

    // Asynchronous reset in the middle of Shift-DR.
    clear_counts();
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 1);
    check("mid_shift_oe", 64'(tdo_oe_o), 64'd1);
    trst_ni = 1'b0; #1;
    check("abort_td_o", 64'(td_o), 64'd0);
    check("abort_oe", 64'(tdo_oe_o), 64'd0);
    check("abort_tlr", 64'(test_logic_reset_o), 64'd1);
    #1 trst_ni = 1'b1;
    tick(0, 0);
    check("abort_rti", {62'd0, test_logic_reset_o, shift_dr_o}, 64'd0);
    check("abort_no_update", 64'(n_upd), 64'd0);
    check("abort_out", {62'd0, td_o, tdo_oe_o}, 64'd0);
    scan_dr(32, '0);
    check("abort_ir_idcode", dout, 64'(Idcode));

    // Select DTMCS and read it with a busy error.
    scan_ir(5'h10);
    check("ir_capture", dout, 64'h05);
    check("ir_oe_cnt", 64'(n_oe), 64'd5);
    check("dtmcs_select", {62'd0, dtmcs_select_o, dmi_access_o}, 64'd2);
    dmi_error_i = 2'd3;
    scan_dr(32, '0);
    check("dtmcs_busy", dout, 64'h1c71);
    check("dtmcs_zero_no_reset", 64'(n_rst), 64'd0);
    scan_dr(32, 64'h0001_0000);
    check("dmireset_pulse", {32'(n_rst), 32'(n_rst_upd)}, {32'd1, 32'd1});
    dmi_error_i = 2'd0;

    // DMI access: serial path comes from downstream.
    scan_ir(5'h11);
    check("dmi_select", {62'd0, dtmcs_select_o, dmi_access_o}, 64'd1);
    scan_dr(41, {$urandom, $urandom});
    check("dmi_access_held", 64'(n_dmi), 64'(n_tick));
    check("dmi_strobes", {32'(n_cap), 16'(n_shift), 16'(n_upd)}, {32'd1, 16'd41, 16'd1});
    check("dmi_td_o", dout & mask(41), dexp & mask(41));
    check("dmi_tdi_fwd", 64'(dmi_tdi_o), 64'(td_i));

    // Unused code behaves as BYPASS.
    scan_ir(5'h05);
    check("bypass_selects", {62'd0, dtmcs_select_o, dmi_access_o}, 64'd0);
    data = 64'($urandom);
    scan_dr(16, data);
    check("bypass_delay", dout & mask(16), {data[62:0], 1'b0} & mask(16));

    // Five TMS=1 clocks from Pause-DR reach Test-Logic-Reset and restore IDCODE.
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    for (int k = 0; k < 5; k++) tick(1, 0);
    check("five_tms_tlr", 64'(test_logic_reset_o), 64'd1);
    tick(0, 0);
    scan_dr(32, '0);
    check("five_tms_idcode", dout, 64'(Idcode));

    // Random IR/DR traffic against the transaction model.
    for (int it = 0; it < 14; it++) begin
      code = codes[$urandom_range(0, 4)];
      if (code == 5'h00) code = 5'($urandom);
      scan_ir(code);
      check("rnd_ir_selects", {62'd0, dtmcs_select_o, dmi_access_o},
            {62'd0, code == 5'h10, code == 5'h11});
      dmi_error_i = 2'($urandom);
      len  = $urandom_range(1, 40);
      data = {$urandom, $urandom};
      scan_dr(len, data);
      full = dr_stream(code, data, dmi_error_i);
      if (code == 5'h11) check("rnd_dmi_out", dout & mask(len), dexp & mask(len));
      else check("rnd_dr_out", dout & mask(len), full[63:0] & mask(len));
      check("rnd_oe_cnt", 64'(n_oe), 64'(len));
      check("rnd_dmireset", 64'(n_rst), 64'((code == 5'h10) && full[len + 16]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
